result_checker: RTL and testbench
=================================

RESULT_CHECKER -- requirements
Module: result_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of the actual, expected and mask buses.
REQ-002 SHALL have parameter ERR_CNT_WIDTH, default 16: width of error_count.
REQ-003 SHALL have parameter IDX_WIDTH, default 32: width of the sample index counters.
REQ-004 SHALL have port clk, input, 1: the single clock (DUT clock domain); all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: single-cycle pulse that arms a check run.
REQ-007 SHALL have port sample_valid, input, 1: actual/expected/mask pair valid this cycle.
REQ-008 SHALL have port actual, input, DATA_WIDTH: DUT output sample.
REQ-009 SHALL have port expected, input, DATA_WIDTH: reference sample read from the vector file.
REQ-010 SHALL have port mask, input, DATA_WIDTH: 1 = compare bit, 0 = don't-care.
REQ-011 SHALL have port end_of_vector, input, 1: pulse marking that the last sample has been presented.
REQ-012 SHALL have port mismatch, output, 1: registered per-sample mismatch flag.
REQ-013 SHALL have port error_count, output, ERR_CNT_WIDTH: saturating count of mismatched samples.
REQ-014 SHALL have port sample_count, output, IDX_WIDTH: number of samples checked.
REQ-015 SHALL have port first_err_idx, output, IDX_WIDTH: index of the first mismatched sample.
REQ-016 SHALL have port first_err_valid, output, 1: first_err_idx holds a captured value.
REQ-017 SHALL have port done, output, 1: the run is finished; level-held.
REQ-018 SHALL have port test_passed, output, 1: meaningful only while done = 1.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-020 SHALL transition IDLE->RUN on start=1, clearing all counters, first_err_valid and mismatch in that same edge.
REQ-021 SHALL ignore sample_valid and end_of_vector while in IDLE.
REQ-022 SHALL in RUN, on sample_valid=1, evaluate miss = |((actual ^ expected) & mask).
REQ-023 SHALL register mismatch one cycle after the sample; mismatch = 0 on cycles following sample_valid=0.
REQ-024 SHALL in RUN increment sample_count by 1 per valid sample; it wraps at 2^IDX_WIDTH.
REQ-025 SHALL increment error_count on miss and saturate at all-ones (no wrap).
REQ-026 SHALL on the first miss of a run capture the current pre-increment sample_count into first_err_idx and set first_err_valid; later misses do not overwrite it.
REQ-027 SHALL transition RUN->DRAIN on end_of_vector=1; a sample_valid in the same cycle is checked and counted.
REQ-028 SHALL hold DRAIN for exactly 1 cycle so that the last mismatch registers, then go DRAIN->DONE.
REQ-029 SHALL assert done=1 in DONE, with test_passed = (error_count == 0) and sample_count != 0.
REQ-030 SHALL keep counters frozen in DONE/DRAIN, and ignore sample_valid there.
REQ-031 SHALL go DONE->RUN on start=1 (re-arm and clear, as in REQ-020); start in RUN or DRAIN is ignored.
REQ-032 SHALL treat end_of_vector=1 with zero samples checked as DONE with test_passed=0.
REQ-033 SHALL mask an all-zero mask word to no mismatch, while the sample is still counted.

Reset
REQ-034 SHALL, on rst_n=0 at a clk edge, in any state (including mid-RUN), force state IDLE and mismatch=0, error_count=0, sample_count=0, first_err_idx=0, first_err_valid=0, done=0, test_passed=0.
REQ-035 SHALL give rst_n priority over start, sample_valid and end_of_vector in the same cycle.

Verification
REQ-036 SHALL cover this scenario: start, then 8 samples with actual=expected, mask=FFFF, then end_of_vector -> done=1 two cycles later, error_count=0, sample_count=8, test_passed=1.
REQ-037 SHALL cover this scenario: 10 samples with misses at indices 3 and 7 -> mismatch pulses 1 cycle after each miss, error_count=2, first_err_idx=3, test_passed=0.
REQ-038 SHALL cover this scenario: actual=0x00FF, expected=0x0000, mask=0xFF00 -> no mismatch, sample counted.
REQ-039 SHALL cover this scenario: ERR_CNT_WIDTH=4 with 20 misses -> error_count stays at 15.
REQ-040 SHALL cover this scenario: rst_n=0 after 5 samples mid-RUN -> next cycle all outputs 0, state IDLE, and samples are ignored until start.
REQ-041 SHALL cover this scenario: end_of_vector coincident with a missing sample -> the sample is counted, error_count increments, and done follows 2 cycles later; start in DONE clears everything and restarts.

Source files
------------

// File: rtl/result_checker.sv
// Masked sample comparator for vector-driven test runs: counts samples and mismatches,
// records where the first mismatch happened, and reports pass/fail once the run ends.
module result_checker #(
  parameter int DATA_WIDTH    = 16,
  parameter int ERR_CNT_WIDTH = 16,
  parameter int IDX_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     sample_valid,
  input  logic [DATA_WIDTH-1:0]    actual,
  input  logic [DATA_WIDTH-1:0]    expected,
  input  logic [DATA_WIDTH-1:0]    mask,
  input  logic                     end_of_vector,
  output logic                     mismatch,
  output logic [ERR_CNT_WIDTH-1:0] error_count,
  output logic [IDX_WIDTH-1:0]     sample_count,
  output logic [IDX_WIDTH-1:0]     first_err_idx,
  output logic                     first_err_valid,
  output logic                     done,
  output logic                     test_passed
);

  // state | meaning
  // IDLE  | waiting for start, samples ignored
  // RUN   | checking and counting samples
  // DRAIN | one cycle so the last mismatch registers
  // DONE  | results frozen, done held high
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state;
  logic   miss;

  assign miss = |((actual ^ expected) & mask);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      mismatch        <= 1'b0;
      error_count     <= '0;
      sample_count    <= '0;
      first_err_idx   <= '0;
      first_err_valid <= 1'b0;
      done            <= 1'b0;
      test_passed     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          mismatch <= 1'b0;
          if (start) begin
            state           <= RUN;
            error_count     <= '0;
            sample_count    <= '0;
            first_err_idx   <= '0;
            first_err_valid <= 1'b0;
            done            <= 1'b0;
            test_passed     <= 1'b0;
          end
        end
        RUN: begin
          if (sample_valid) begin
            mismatch     <= miss;
            sample_count <= sample_count + 1'b1;
            if (miss) begin
              // saturate rather than wrap so a long failing run never reads as clean
              if (error_count != {ERR_CNT_WIDTH{1'b1}})
                error_count <= error_count + 1'b1;
              if (!first_err_valid) begin
                first_err_idx   <= sample_count;
                first_err_valid <= 1'b1;
              end
            end
          end else begin
            mismatch <= 1'b0;
          end
          if (end_of_vector)
            state <= DRAIN;
        end
        DRAIN: begin
          mismatch    <= 1'b0;
          state       <= DONE;
          done        <= 1'b1;
          test_passed <= (error_count == '0) && (sample_count != '0);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_checker.sv
// Directed bench for result_checker: table-driven runs plus hand-written corner sequences.
module tb_result_checker;

  logic        clk = 1'b0;
  logic        rst_n, start, sample_valid, end_of_vector;
  logic [15:0] actual, expected, mask;

  logic        mismatch, first_err_valid, done, test_passed;
  logic [15:0] error_count;
  logic [31:0] sample_count, first_err_idx;

  logic        mismatch4, first_err_valid4, done4, test_passed4;
  logic [3:0]  error_count4;
  logic [31:0] sample_count4, first_err_idx4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  result_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid),
    .actual(actual), .expected(expected), .mask(mask), .end_of_vector(end_of_vector),
    .mismatch(mismatch), .error_count(error_count), .sample_count(sample_count),
    .first_err_idx(first_err_idx), .first_err_valid(first_err_valid),
    .done(done), .test_passed(test_passed)
  );

  result_checker #(.ERR_CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid),
    .actual(actual), .expected(expected), .mask(mask), .end_of_vector(end_of_vector),
    .mismatch(mismatch4), .error_count(error_count4), .sample_count(sample_count4),
    .first_err_idx(first_err_idx4), .first_err_valid(first_err_valid4),
    .done(done4), .test_passed(test_passed4)
  );

  typedef struct {
    logic [15:0] act;
    logic [15:0] exp;
    logic [15:0] msk;
    logic        start_in;
    logic        miss;
  } vec_t;

  vec_t vec[32];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic idle_inputs();
    start = 0; sample_valid = 0; end_of_vector = 0;
    actual = 0; expected = 0; mask = 0;
  endtask

  task automatic set_vec(input int k, input logic [15:0] a, input logic [15:0] e,
                         input logic [15:0] m, input logic s, input logic mi);
    vec[k].act = a; vec[k].exp = e; vec[k].msk = m; vec[k].start_in = s; vec[k].miss = mi;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_mismatch"}, {31'b0, mismatch}, 0);
    chk({tag, "_err"}, {16'b0, error_count}, 0);
    chk({tag, "_cnt"}, sample_count, 0);
    chk({tag, "_fidx"}, first_err_idx, 0);
    chk({tag, "_fvalid"}, {31'b0, first_err_valid}, 0);
    chk({tag, "_done"}, {31'b0, done}, 0);
    chk({tag, "_passed"}, {31'b0, test_passed}, 0);
  endtask

  // Arms a run, plays vec[first +: n], then a separate end_of_vector cycle.
  task automatic run_table(input string tag, input int first, input int n,
                           input int exp_err, input int exp_fidx, input logic exp_fvalid);
    start = 1; tick(); start = 0;
    chk({tag, "_arm_cnt"}, sample_count, 0);
    for (int i = 0; i < n; i++) begin
      actual = vec[first+i].act; expected = vec[first+i].exp; mask = vec[first+i].msk;
      start = vec[first+i].start_in; sample_valid = 1;
      tick();
      chk($sformatf("%s_mismatch%0d", tag, i), {31'b0, mismatch}, {31'b0, vec[first+i].miss});
      chk($sformatf("%s_cnt%0d", tag, i), sample_count, i + 1);
    end
    idle_inputs(); end_of_vector = 1; tick(); end_of_vector = 0;
    chk({tag, "_drain_done"}, {31'b0, done}, 0);
    chk({tag, "_drain_mismatch"}, {31'b0, mismatch}, 0);
    tick();
    chk({tag, "_done"}, {31'b0, done}, 1);
    chk({tag, "_err"}, {16'b0, error_count}, exp_err);
    chk({tag, "_cnt"}, sample_count, n);
    chk({tag, "_fidx"}, first_err_idx, exp_fidx);
    chk({tag, "_fvalid"}, {31'b0, first_err_valid}, {31'b0, exp_fvalid});
    chk({tag, "_passed"}, {31'b0, test_passed}, (exp_err == 0) ? 1 : 0);
  endtask

  initial begin
    // run A: 8 matching samples
    for (int i = 0; i < 8; i++) set_vec(i, 16'(i * 16'h1111), 16'(i * 16'h1111), 16'hFFFF, 0, 0);
    // run B: 10 samples, misses at 3 and 7, start pulse mid-run at 5
    for (int i = 8; i < 18; i++) set_vec(i, 16'(i), 16'(i), 16'hFFFF, 0, 0);
    set_vec(11, 16'h0100, 16'h0000, 16'hFFFF, 0, 1);
    set_vec(13, 16'h1234, 16'h1235, 16'hFFFE, 1, 0);
    set_vec(15, 16'h8000, 16'h0000, 16'h8000, 0, 1);
    // run C: masked-off difference and all-zero mask
    set_vec(18, 16'h00FF, 16'h0000, 16'hFF00, 0, 0);
    set_vec(19, 16'hDEAD, 16'hBEEF, 16'h0000, 0, 0);

    idle_inputs();
    rst_n = 0; tick(); tick();
    check_cleared("reset");
    rst_n = 1; tick();
    check_cleared("idle");

    run_table("allpass", 0, 8, 0, 0, 0);
    run_table("twomiss", 8, 10, 2, 3, 1);
    run_table("masked", 18, 2, 0, 0, 0);

    // saturation: 20 misses, 4-bit counter holds at 15
    start = 1; tick(); start = 0;
    actual = 16'h0001; expected = 16'h0000; mask = 16'h0001; sample_valid = 1;
    for (int i = 0; i < 20; i++) tick();
    sample_valid = 0;
    chk("sat_err4", {28'b0, error_count4}, 15);
    chk("sat_err16", {16'b0, error_count}, 20);
    chk("sat_cnt4", sample_count4, 20);
    chk("sat_fidx4", first_err_idx4, 0);
    end_of_vector = 1; tick(); end_of_vector = 0; tick();
    chk("sat_done4", {31'b0, done4}, 1);
    chk("sat_passed4", {31'b0, test_passed4}, 0);

    // reset mid-run after 5 samples, with start/valid/eov all asserted
    idle_inputs();
    start = 1; tick(); start = 0;
    actual = 16'h0F0F; expected = 16'h0F0E; mask = 16'hFFFF; sample_valid = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("midrun_cnt", sample_count, 5);
    rst_n = 0; start = 1; end_of_vector = 1; tick();
    check_cleared("midrun_rst");
    rst_n = 1; start = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("ignored_cnt%0d", i), sample_count, 0);
      chk($sformatf("ignored_mis%0d", i), {31'b0, mismatch}, 0);
      chk($sformatf("ignored_done%0d", i), {31'b0, done}, 0);
    end
    idle_inputs(); tick();

    // end_of_vector with no samples
    start = 1; tick(); start = 0;
    end_of_vector = 1; tick(); end_of_vector = 0; tick();
    chk("empty_done", {31'b0, done}, 1);
    chk("empty_passed", {31'b0, test_passed}, 0);
    chk("empty_cnt", sample_count, 0);

    // restart from DONE, 3 good samples then a miss coincident with end_of_vector
    start = 1; tick(); start = 0;
    chk("rearm_done", {31'b0, done}, 0);
    actual = 16'h5555; expected = 16'h5555; mask = 16'hFFFF; sample_valid = 1;
    for (int i = 0; i < 3; i++) tick();
    expected = 16'h5554; end_of_vector = 1; tick(); end_of_vector = 0;
    chk("eovmiss_mismatch", {31'b0, mismatch}, 1);
    chk("eovmiss_err", {16'b0, error_count}, 1);
    chk("eovmiss_cnt", sample_count, 4);
    chk("eovmiss_fidx", first_err_idx, 3);
    chk("eovmiss_fvalid", {31'b0, first_err_valid}, 1);
    chk("eovmiss_done_early", {31'b0, done}, 0);
    tick();
    chk("eovmiss_done", {31'b0, done}, 1);
    chk("eovmiss_drain_mis", {31'b0, mismatch}, 0);
    chk("eovmiss_drain_cnt", sample_count, 4);
    chk("eovmiss_drain_err", {16'b0, error_count}, 1);
    chk("eovmiss_passed", {31'b0, test_passed}, 0);
    tick();
    chk("frozen_cnt", sample_count, 4);
    chk("frozen_mis", {31'b0, mismatch}, 0);
    chk("frozen_done", {31'b0, done}, 1);
    sample_valid = 0; start = 1; tick(); start = 0;
    check_cleared("restart");
    sample_valid = 1; expected = 16'h5555; end_of_vector = 1; tick();
    sample_valid = 0; end_of_vector = 0; tick();
    chk("restart_done", {31'b0, done}, 1);
    chk("restart_passed", {31'b0, test_passed}, 1);
    chk("restart_cnt", sample_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
